// File: rtl/sdram_prefetch_buf_pkg.sv
// Shared FSM state type for the SDRAM read-prefetch buffer.
package sdram_prefetch_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_PF_REQ  = 3'd5,
    ST_PF_WAIT = 3'd6
  } state_t;

endpackage

// File: rtl/sdram_prefetch_buf_pf_fifo.sv
// DEPTH x 32 circular FIFO of prefetched words; the head word is always visible.
module pf_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata,
  output logic [$clog2(DEPTH):0]   o_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_cnt;

  // Flush just discards the contents by catching the read pointer up.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_cnt    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/sdram_prefetch_buf.sv
// Read-prefetch line buffer between the Wishbone bram decode and sdram_controller;
// sequential reads hit a small FIFO refilled while the bus is idle, writes pass through.
module sdram_prefetch_buf
  import sdram_prefetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_en,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [31:0]   wb_wdata,
  output logic          wb_ack,
  output logic [31:0]   wb_rdata,
  output logic [AW-1:0] ctrl_addr,
  output logic          ctrl_rw,
  output logic [31:0]   ctrl_wdata,
  output logic          ctrl_in_valid,
  input  logic          ctrl_busy,
  input  logic [31:0]   ctrl_rdata,
  input  logic          ctrl_out_valid
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_head, w_head_nxt;
  logic [AW-1:0] r_req_addr, w_req_addr_nxt;
  logic [31:0]   r_req_wdata, w_req_wdata_nxt;
  logic          r_wb_ack, w_wb_ack_nxt;
  logic [31:0]   r_wb_rdata, w_wb_rdata_nxt;
  logic [AW-1:0] r_ctrl_addr, w_ctrl_addr_nxt;
  logic          r_ctrl_rw, w_ctrl_rw_nxt;
  logic [31:0]   r_ctrl_wdata, w_ctrl_wdata_nxt;
  logic          r_ctrl_in_valid, w_ctrl_in_valid_nxt;

  logic          w_push, w_pop, w_flush;
  logic [31:0]   w_fifo_rdata;
  logic [CW-1:0] w_cnt;
  logic          w_req, w_hit, w_in_range, w_full;
  logic [AW-1:0] w_tail;
  logic [AW-3:0] w_off;

  pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (ctrl_rdata),
    .o_rdata (w_fifo_rdata),
    .o_cnt   (w_cnt)
  );

  // Word offset from head, modulo 2^AW, makes the write-hit window wrap correctly.
  assign w_req      = wb_en && !r_wb_ack;
  assign w_tail     = r_head + AW'({w_cnt, 2'b00});
  assign w_off      = wb_addr[AW-1:2] - r_head[AW-1:2];
  assign w_in_range = (w_off < (AW-2)'(w_cnt));
  assign w_hit      = (w_cnt != '0) && (wb_addr[AW-1:2] == r_head[AW-1:2]);
  assign w_full     = (w_cnt == CW'(DEPTH));

  always_comb begin
    w_state_nxt         = r_state;
    w_head_nxt          = r_head;
    w_req_addr_nxt      = r_req_addr;
    w_req_wdata_nxt     = r_req_wdata;
    w_wb_ack_nxt        = 1'b0;
    w_wb_rdata_nxt      = r_wb_rdata;
    w_ctrl_addr_nxt     = r_ctrl_addr;
    w_ctrl_rw_nxt       = r_ctrl_rw;
    w_ctrl_wdata_nxt    = r_ctrl_wdata;
    w_ctrl_in_valid_nxt = 1'b0;
    w_push              = 1'b0;
    w_pop               = 1'b0;
    w_flush             = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req && !wb_we) begin
          if (w_hit) begin
            w_wb_ack_nxt   = 1'b1;
            w_wb_rdata_nxt = w_fifo_rdata;
            w_pop          = 1'b1;
            w_head_nxt     = r_head + AW'(4);
          end else begin
            w_flush        = 1'b1;
            w_req_addr_nxt = wb_addr;
            w_state_nxt    = ST_RD_REQ;
          end
        end else if (w_req) begin
          w_flush         = w_in_range;
          w_req_addr_nxt  = wb_addr;
          w_req_wdata_nxt = wb_wdata;
          w_state_nxt     = ST_WR_REQ;
        end else if (!w_full) begin
          w_state_nxt = ST_PF_REQ;
        end
      end
      ST_RD_REQ: begin
        if (!ctrl_busy) begin
          w_ctrl_in_valid_nxt = 1'b1;
          w_ctrl_rw_nxt       = 1'b0;
          w_ctrl_addr_nxt     = r_req_addr;
          w_state_nxt         = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (ctrl_out_valid) begin
          w_wb_ack_nxt   = 1'b1;
          w_wb_rdata_nxt = ctrl_rdata;
          w_head_nxt     = {r_req_addr[AW-1:2], 2'b00} + AW'(4);
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        if (!ctrl_busy) begin
          w_ctrl_in_valid_nxt = 1'b1;
          w_ctrl_rw_nxt       = 1'b1;
          w_ctrl_addr_nxt     = r_req_addr;
          w_ctrl_wdata_nxt    = r_req_wdata;
          w_wb_ack_nxt        = 1'b1;
          w_state_nxt         = ST_IDLE;
        end
      end
      ST_PF_REQ: begin
        // A bus request before the pulse abandons the prefetch so IDLE can serve it.
        if (w_req) begin
          w_state_nxt = ST_IDLE;
        end else if (!ctrl_busy) begin
          w_ctrl_in_valid_nxt = 1'b1;
          w_ctrl_rw_nxt       = 1'b0;
          w_ctrl_addr_nxt     = w_tail;
          w_state_nxt         = ST_PF_WAIT;
        end
      end
      ST_PF_WAIT: begin
        if (ctrl_out_valid) begin
          w_push      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_head          <= '0;
      r_req_addr      <= '0;
      r_req_wdata     <= '0;
      r_wb_ack        <= 1'b0;
      r_wb_rdata      <= '0;
      r_ctrl_addr     <= '0;
      r_ctrl_rw       <= 1'b0;
      r_ctrl_wdata    <= '0;
      r_ctrl_in_valid <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_head          <= w_head_nxt;
      r_req_addr      <= w_req_addr_nxt;
      r_req_wdata     <= w_req_wdata_nxt;
      r_wb_ack        <= w_wb_ack_nxt;
      r_wb_rdata      <= w_wb_rdata_nxt;
      r_ctrl_addr     <= w_ctrl_addr_nxt;
      r_ctrl_rw       <= w_ctrl_rw_nxt;
      r_ctrl_wdata    <= w_ctrl_wdata_nxt;
      r_ctrl_in_valid <= w_ctrl_in_valid_nxt;
    end
  end

  assign wb_ack        = r_wb_ack;
  assign wb_rdata      = r_wb_rdata;
  assign ctrl_addr     = r_ctrl_addr;
  assign ctrl_rw       = r_ctrl_rw;
  assign ctrl_wdata    = r_ctrl_wdata;
  assign ctrl_in_valid = r_ctrl_in_valid;

endmodule

// File: tb/tb_sdram_prefetch_buf.sv
// Directed bench for sdram_prefetch_buf with a latency-programmable controller model.
module tb_sdram_prefetch_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en = 1'b0;
  logic        wb_we = 1'b0;
  logic [22:0] wb_addr = '0;
  logic [31:0] wb_wdata = '0;
  logic        wb_ack;
  logic [31:0] wb_rdata;
  logic [22:0] ctrl_addr;
  logic        ctrl_rw;
  logic [31:0] ctrl_wdata;
  logic        ctrl_in_valid;
  logic        ctrl_busy = 1'b0;
  logic [31:0] ctrl_rdata = '0;
  logic        ctrl_out_valid = 1'b0;

  int total = 0;
  int bad = 0;

  sdram_prefetch_buf #(.DEPTH(4), .AW(23)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_en          (wb_en),
    .wb_we          (wb_we),
    .wb_addr        (wb_addr),
    .wb_wdata       (wb_wdata),
    .wb_ack         (wb_ack),
    .wb_rdata       (wb_rdata),
    .ctrl_addr      (ctrl_addr),
    .ctrl_rw        (ctrl_rw),
    .ctrl_wdata     (ctrl_wdata),
    .ctrl_in_valid  (ctrl_in_valid),
    .ctrl_busy      (ctrl_busy),
    .ctrl_rdata     (ctrl_rdata),
    .ctrl_out_valid (ctrl_out_valid)
  );

  always #5 clk = ~clk;

  // Controller model: busy for 'lat' cycles after a pulse, reads return A500_0000|addr
  // unless the address was written.
  int          lat = 2;
  int          m_cnt = 0;
  logic [22:0] m_addr = '0;
  logic        m_rw = 1'b0;
  logic        wr_ok = 1'b0;
  logic [22:0] wr_a = '0;
  logic [31:0] wr_d = '0;
  int          viol = 0;
  int          ack_cnt = 0;
  logic [22:0] log_a[$];
  logic        log_rw[$];
  logic [31:0] log_d[$];

  function automatic logic [31:0] memval(input logic [22:0] a);
    if (wr_ok && a == wr_a) return wr_d;
    return 32'hA500_0000 | {9'd0, a};
  endfunction

  always @(posedge clk) begin
    ctrl_out_valid <= 1'b0;
    if (ctrl_in_valid) begin
      if (ctrl_busy) viol <= viol + 1;
      ctrl_busy <= 1'b1;
      m_cnt     <= lat;
      m_addr    <= ctrl_addr;
      m_rw      <= ctrl_rw;
      log_a.push_back(ctrl_addr);
      log_rw.push_back(ctrl_rw);
      log_d.push_back(ctrl_wdata);
      if (ctrl_rw) begin
        wr_ok <= 1'b1;
        wr_a  <= ctrl_addr;
        wr_d  <= ctrl_wdata;
      end
    end else if (ctrl_busy) begin
      if (m_cnt <= 1) begin
        ctrl_busy <= 1'b0;
        if (!m_rw) begin
          ctrl_out_valid <= 1'b1;
          ctrl_rdata     <= memval(m_addr);
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(posedge clk) if (wb_ack) ack_cnt <= ack_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] la(input int i);
    return (i < log_a.size()) ? {9'd0, log_a[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] lrw(input int i);
    return (i < log_rw.size()) ? {31'd0, log_rw[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ld(input int i);
    return (i < log_d.size()) ? log_d[i] : 32'hFFFF_FFFF;
  endfunction

  // Called at a negedge; returns data and cycles from request to visible ack.
  task automatic do_read(input logic [22:0] a, output logic [31:0] d, output int n);
    wb_en = 1'b1; wb_we = 1'b0; wb_addr = a; n = 0;
    do begin @(negedge clk); n++; end while (!wb_ack && n < 200);
    chk("read_ack", {31'd0, wb_ack}, 32'd1);
    d = wb_rdata;
    wb_en = 1'b0;
  endtask

  task automatic do_write(input logic [22:0] a, input logic [31:0] dat);
    int n = 0;
    wb_en = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdata = dat;
    do begin @(negedge clk); n++; end while (!wb_ack && n < 200);
    chk("write_ack", {31'd0, wb_ack}, 32'd1);
    wb_en = 1'b0; wb_we = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int          n;
    int          a0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_wb_ack", {31'd0, wb_ack}, 32'd0);
    chk("rst_wb_rdata", wb_rdata, 32'd0);
    chk("rst_ctrl_in_valid", {31'd0, ctrl_in_valid}, 32'd0);
    chk("rst_ctrl_rw", {31'd0, ctrl_rw}, 32'd0);
    chk("rst_ctrl_addr", {9'd0, ctrl_addr}, 32'd0);
    chk("rst_ctrl_wdata", ctrl_wdata, 32'd0);
    chk("rst_cnt", 32'(dut.w_cnt), 32'd0);
    rst = 1'b0;

    // Idle fill: four prefetches 0,4,8,C then nothing more
    repeat (50) @(negedge clk);
    chk("fill_n", 32'(log_a.size()), 32'd4);
    chk("fill_a0", la(0), 32'h0);
    chk("fill_a1", la(1), 32'h4);
    chk("fill_a2", la(2), 32'h8);
    chk("fill_a3", la(3), 32'hC);
    chk("fill_rw0", lrw(0), 32'd0);
    chk("fill_cnt", 32'(dut.w_cnt), 32'd4);

    // Sequential hits, each followed by a refill at the tail
    log_a.delete(); log_rw.delete(); log_d.delete();
    do_read(23'h0, d, n);
    chk("seq0_data", d, 32'hA500_0000);
    chk("seq0_lat", 32'(n), 32'd1);
    repeat (20) @(negedge clk);
    do_read(23'h4, d, n);
    chk("seq1_data", d, 32'hA500_0004);
    chk("seq1_lat", 32'(n), 32'd1);
    repeat (20) @(negedge clk);
    do_read(23'h8, d, n);
    chk("seq2_data", d, 32'hA500_0008);
    chk("seq2_lat", 32'(n), 32'd1);
    repeat (20) @(negedge clk);
    chk("seq_pf_n", 32'(log_a.size()), 32'd3);
    chk("seq_pf0", la(0), 32'h10);
    chk("seq_pf1", la(1), 32'h14);
    chk("seq_pf2", la(2), 32'h18);
    chk("seq_cnt", 32'(dut.w_cnt), 32'd4);

    // Miss with full FIFO
    log_a.delete(); log_rw.delete(); log_d.delete();
    do_read(23'h100, d, n);
    chk("miss_data", d, 32'hA500_0100);
    repeat (40) @(negedge clk);
    chk("miss_n", 32'(log_a.size()), 32'd5);
    chk("miss_a0", la(0), 32'h100);
    chk("miss_pf0", la(1), 32'h104);
    chk("miss_pf3", la(4), 32'h110);
    chk("miss_cnt", 32'(dut.w_cnt), 32'd4);

    // Write to a buffered word flushes; re-read misses and sees new data
    do_read(23'h4, d, n);
    chk("pre_wr_data", d, 32'hA500_0004);
    repeat (40) @(negedge clk);
    log_a.delete(); log_rw.delete(); log_d.delete();
    do_write(23'h8, 32'h1234_5678);
    chk("wr_flush_cnt", 32'(dut.w_cnt), 32'd0);
    do_read(23'h8, d, n);
    chk("wr_reread_data", d, 32'h1234_5678);
    chk("wr_a", la(0), 32'h8);
    chk("wr_rw", lrw(0), 32'd1);
    chk("wr_wdata", ld(0), 32'h1234_5678);
    chk("wr_miss_a", la(1), 32'h8);
    chk("wr_miss_rw", lrw(1), 32'd0);

    // Request held behind a slow prefetch
    repeat (40) @(negedge clk);
    lat = 5;
    do_read(23'hC, d, n);
    chk("pf_pop_data", d, 32'hA500_000C);
    repeat (2) @(negedge clk);
    a0 = ack_cnt;
    do_read(23'h10, d, n);
    chk("held_data", d, 32'hA500_0010);
    chk("held_lat", 32'(n), 32'd8);
    repeat (5) @(negedge clk);
    chk("held_single_ack", 32'(ack_cnt - a0), 32'd1);
    lat = 2;

    // Address wrap modulo 2^23
    repeat (20) @(negedge clk);
    do_read(23'h7FFFF8, d, n);
    chk("wrap_miss_data", d, 32'hA57F_FFF8);
    repeat (40) @(negedge clk);
    do_read(23'h7FFFFC, d, n);
    chk("wrap_top_data", d, 32'hA57F_FFFC);
    chk("wrap_top_lat", 32'(n), 32'd1);
    repeat (20) @(negedge clk);
    do_read(23'h0, d, n);
    chk("wrap_zero_data", d, 32'hA500_0000);
    chk("wrap_zero_lat", 32'(n), 32'd1);

    // Reset while RD_WAIT, stale controller data must be ignored
    repeat (40) @(negedge clk);
    lat = 8;
    a0 = ack_cnt;
    wb_en = 1'b1; wb_we = 1'b0; wb_addr = 23'h200;
    repeat (3) @(negedge clk);
    rst = 1'b1; wb_en = 1'b0;
    log_a.delete(); log_rw.delete(); log_d.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!ctrl_out_valid && n < 40) begin @(negedge clk); n++; end
    chk("stale_seen", {31'd0, ctrl_out_valid}, 32'd1);
    chk("stale_cnt0", 32'(dut.w_cnt), 32'd0);
    @(negedge clk);
    chk("stale_cnt1", 32'(dut.w_cnt), 32'd0);
    repeat (10) @(negedge clk);
    chk("stale_no_ack", 32'(ack_cnt - a0), 32'd0);
    chk("stale_first_pf", la(0), 32'h0);
    lat = 2;
    repeat (60) @(negedge clk);
    do_read(23'h0, d, n);
    chk("post_rst_data", d, 32'hA500_0000);
    chk("post_rst_lat", 32'(n), 32'd1);

    chk("no_issue_while_busy", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
